// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with valid/ready input handshake.
// Mult/div hold func and raise busy for a fixed iterative-unit budget.
module alu_control_seq #(
  parameter int FUNC_W     = 4,
  parameter int OP_W       = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [5:0]        funct,
  output logic              out_valid,
  output logic [FUNC_W-1:0] func,
  output logic              is_jr,
  output logic              illegal,
  output logic              busy,
  output logic              mc_done
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ?
                         MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MULTI
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [FUNC_W-1:0] func_n;
  logic              jr_n, ill_n, ov_n;

  logic [3:0]        code;
  logic              d_jr, d_ill, d_mc;
  logic [CNT_W-1:0]  d_cnt;
  logic              op_hi;
  logic [OP_W-1:0]   op_lim;
  logic [2:0]        op3;
  logic              accept;

  assign op_lim = OP_W'(7);
  assign op_hi  = alu_op > op_lim;
  assign op3    = alu_op[2:0];

  always_comb begin
    code  = 4'd7;
    d_jr  = 1'b0;
    d_ill = 1'b0;
    d_mc  = 1'b0;
    d_cnt = '0;
    if (op_hi) begin
      d_ill = 1'b1;
    end else begin
      unique case (op3)
        3'b000: begin
          unique case (funct)
            6'h20: code = 4'd0;
            6'h22: code = 4'd1;
            6'h24: code = 4'd2;
            6'h25: code = 4'd3;
            6'h27: code = 4'd4;
            6'h2A: code = 4'd5;
            6'h00: code = 4'd8;
            6'h02: code = 4'd9;
            6'h18: begin
              code  = 4'd10;
              d_mc  = 1'b1;
              d_cnt = CNT_W'(MUL_CYCLES - 1);
            end
            6'h1A: begin
              code  = 4'd11;
              d_mc  = 1'b1;
              d_cnt = CNT_W'(DIV_CYCLES - 1);
            end
            6'h08: begin
              code = 4'd15;
              d_jr = 1'b1;
            end
            default: d_ill = 1'b1;
          endcase
        end
        3'b001: code = 4'd1;
        3'b010: code = 4'd0;
        3'b011: code = 4'd1;
        3'b100: code = 4'd2;
        3'b101: code = 4'd5;
        3'b110: code = 4'd6;
        default: code = 4'd1;
      endcase
    end
  end

  assign busy     = (state == MULTI);
  assign mc_done  = busy && (cnt == '0);
  assign in_ready = ~busy | mc_done;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    func_n  = func;
    jr_n    = 1'b0;
    ill_n   = 1'b0;
    ov_n    = 1'b0;
    if (state == MULTI && cnt != '0) begin
      cnt_n = cnt - 1'b1;
      ov_n  = 1'b1;
    end else if (accept) begin
      func_n = FUNC_W'(code);
      jr_n   = d_jr;
      ill_n  = d_ill;
      ov_n   = ~d_jr;
      if (d_mc) begin
        state_n = MULTI;
        cnt_n   = d_cnt;
      end else begin
        state_n = EXEC;
        cnt_n   = '0;
      end
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state     <= IDLE;
      cnt       <= '0;
      func      <= '0;
      is_jr     <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      func      <= func_n;
      is_jr     <= jr_n;
      illegal   <= ill_n;
      out_valid <= ov_n;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: decode results queued
// at accept and compared on the following cycle.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid;
  logic [2:0] alu_op;
  logic [5:0] funct;
  logic       in_ready, out_valid, is_jr, illegal, busy, mc_done;
  logic [3:0] func;

  int n_chk  = 0;
  int n_pass = 0;
  logic [6:0] sb[$];
  logic       pend = 1'b0;

  always #5 clk = ~clk;

  alu_control_seq #(
    .FUNC_W(4), .OP_W(3), .MUL_CYCLES(4), .DIV_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct),
    .out_valid(out_valid), .func(func),
    .is_jr(is_jr), .illegal(illegal),
    .busy(busy), .mc_done(mc_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {out_valid, illegal, is_jr, func}
  function automatic logic [6:0] exp_of(input logic [2:0] op,
                                        input logic [5:0] f);
    logic [3:0] c;
    logic jr, il;
    jr = 1'b0; il = 1'b0; c = 4'd7;
    case (op)
      3'd0: case (f)
        6'h20: c = 4'd0;
        6'h22: c = 4'd1;
        6'h24: c = 4'd2;
        6'h25: c = 4'd3;
        6'h27: c = 4'd4;
        6'h2A: c = 4'd5;
        6'h00: c = 4'd8;
        6'h02: c = 4'd9;
        6'h18: c = 4'd10;
        6'h1A: c = 4'd11;
        6'h08: begin c = 4'd15; jr = 1'b1; end
        default: il = 1'b1;
      endcase
      3'd1: c = 4'd1;
      3'd2: c = 4'd0;
      3'd3: c = 4'd1;
      3'd4: c = 4'd2;
      3'd5: c = 4'd5;
      3'd6: c = 4'd6;
      default: c = 4'd1;
    endcase
    return {~jr, il, jr, c};
  endfunction

  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("result", {25'd0, out_valid, illegal, is_jr, func},
               {25'd0, sb.pop_front()});
    end
    pend = in_valid & in_ready & ~flush & rst_n;
    if (pend) sb.push_back(exp_of(alu_op, funct));
  end

  task automatic send(input logic [2:0] op, input logic [5:0] f);
    int n;
    alu_op = op; funct = f; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, mc_done}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_func"}, {28'd0, func}, 32'd0);
    chk({tag, "_jr"}, {31'd0, is_jr}, 32'd0);
    chk({tag, "_ill"}, {31'd0, illegal}, 32'd0);
  endtask

  task automatic abort_div(input bit use_rst);
    send(3'd0, 6'h1A);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        if (use_rst) rst_n = 1'b0;
        else flush = 1'b1;
      end
      @(negedge clk);
      chk("ab_busy", {31'd0, busy}, 32'd1);
      chk("ab_done", {31'd0, mc_done}, 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk_idle(use_rst ? "rst_ab" : "fl_ab");
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    alu_op = '0; funct = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset");

    send(3'd0, 6'h22);
    @(negedge clk);
    chk("sub_ov", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("sub_ov_off", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    send(3'd0, 6'h18);
    alu_op = 3'd0; funct = 6'h20; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mul_busy", {31'd0, busy}, 32'd1);
      chk("mul_ov", {31'd0, out_valid}, 32'd1);
      chk("mul_func", {28'd0, func}, 32'd10);
      chk("mul_rdy", {31'd0, in_ready}, (i == 3) ? 32'd1 : 32'd0);
      chk("mul_done", {31'd0, mc_done}, (i == 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy}, 32'd0);
    chk("b2b_ov", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    begin
      logic [2:0] ops [4] = '{3'd1, 3'd2, 3'd5, 3'd6};
      for (int i = 0; i < 4; i++) begin
        alu_op = ops[i]; funct = 6'h3F; in_valid = 1'b1;
        @(negedge clk);
        if (i > 0) chk("strm_ov", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("strm_ov_last", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end

    send(3'd0, 6'h08);
    send(3'd0, 6'h3F);
    @(negedge clk);
    chk("ill_set", {31'd0, illegal}, 32'd1);
    @(negedge clk);
    chk("ill_clr", {31'd0, illegal}, 32'd0);
    chk("jr_clr", {31'd0, is_jr}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(3'(i), 6'h24 + 6'(i));
    end
    repeat (2) @(posedge clk); #1;

    alu_op = 3'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_drop_ov", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    abort_div(1'b0);
    @(posedge clk); #1;
    abort_div(1'b1);
    @(posedge clk); #1;

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
